// File: rtl/byte_2_word.sv
// byte_2_word: pairs two received bytes, low byte first, into a 16-bit word; a stray low byte is dropped on timeout
module byte_2_word #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        byte_dv,
  input  logic [7:0]  byte_in,
  output logic        word_dv,
  output logic [15:0] word,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic {IDLE, WAIT_HI} state_t;
  state_t state;
  logic [7:0] lo;
  logic [TO_W-1:0] cnt;
  logic expire;
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign busy = (state == WAIT_HI);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lo <= '0;
      cnt <= '0;
      word <= '0;
      word_dv <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      word_dv <= 1'b0;
      timeout_err <= 1'b0;
      if (ce) begin
        if (state == IDLE) begin
          if (byte_dv) begin
            lo <= byte_in;
            cnt <= '0;
            state <= WAIT_HI;
          end
        end else if (byte_dv) begin
          word <= {byte_in, lo};
          word_dv <= 1'b1;
          state <= IDLE;
        end else if (expire) begin
          timeout_err <= 1'b1;
          state <= IDLE;
        end else begin
          // saturates so a disabled timeout never wraps
          cnt <= cnt + TO_W'(cnt != '1);
        end
      end
    end
  end
endmodule

// File: tb/tb_byte_2_word.sv
// tb_byte_2_word: directed checks of byte pairing, timeout, clock enable and async reset
module tb_byte_2_word;
  logic clk = 0, rst = 1, ce = 1, byte_dv = 0;
  logic [7:0] byte_in = 0;
  logic word_dv, busy, timeout_err;
  logic [15:0] word;
  int checks = 0, errors = 0;

  byte_2_word #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .byte_dv(byte_dv), .byte_in(byte_in),
    .word_dv(word_dv), .word(word), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_dv = 1;
    byte_in = b;
    @(posedge clk);
    #1;
    byte_dv = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_word", word, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_dv", word_dv, 0);
    chk("rst_to", timeout_err, 0);
    idle(2);
    rst = 0;
    // 1: spaced bytes
    send(8'h34);
    chk("t1_busy_lo", busy, 1);
    chk("t1_dv_lo", word_dv, 0);
    idle(2);
    chk("t1_busy_wait", busy, 1);
    send(8'h12);
    chk("t1_dv", word_dv, 1);
    chk("t1_word", word, 16'h1234);
    chk("t1_busy_done", busy, 0);
    idle(1);
    chk("t1_dv_pulse", word_dv, 0);
    chk("t1_word_hold", word, 16'h1234);
    // 2: back-to-back
    send(8'hAA);
    send(8'hBB);
    chk("t2_dv1", word_dv, 1);
    chk("t2_word1", word, 16'hBBAA);
    send(8'hCC);
    chk("t2_dv_mid", word_dv, 0);
    chk("t2_busy_mid", busy, 1);
    send(8'hDD);
    chk("t2_dv2", word_dv, 1);
    chk("t2_word2", word, 16'hDDCC);
    idle(1);
    // 3: timeout
    send(8'h55);
    idle(7);
    chk("t3_busy_pre", busy, 1);
    chk("t3_to_pre", timeout_err, 0);
    idle(1);
    chk("t3_to", timeout_err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_word", word, 16'hDDCC);
    chk("t3_dv", word_dv, 0);
    idle(1);
    chk("t3_to_pulse", timeout_err, 0);
    send(8'h01);
    send(8'h02);
    chk("t3_resync", word, 16'h0201);
    chk("t3_resync_dv", word_dv, 1);
    // 4: byte on the expiry cycle wins
    send(8'h55);
    idle(7);
    chk("t4_busy", busy, 1);
    send(8'h66);
    chk("t4_dv", word_dv, 1);
    chk("t4_word", word, 16'h6655);
    chk("t4_to", timeout_err, 0);
    idle(1);
    chk("t4_to_after", timeout_err, 0);
    // 5: clock enable
    ce = 0;
    send(8'hEE);
    chk("t5_busy1", busy, 0);
    chk("t5_dv1", word_dv, 0);
    send(8'hFF);
    chk("t5_busy2", busy, 0);
    chk("t5_word", word, 16'h6655);
    ce = 1;
    send(8'h11);
    ce = 0;
    idle(20);
    chk("t5_frozen_busy", busy, 1);
    chk("t5_frozen_to", timeout_err, 0);
    ce = 1;
    send(8'h22);
    chk("t5_word2", word, 16'h2211);
    chk("t5_dv2", word_dv, 1);
    // 6: async reset mid-word
    send(8'h77);
    chk("t6_busy_pre", busy, 1);
    #2 rst = 1;
    #1;
    chk("t6_busy_rst", busy, 0);
    chk("t6_word_rst", word, 16'h0000);
    @(posedge clk);
    #1 rst = 0;
    send(8'h88);
    send(8'h99);
    chk("t6_word", word, 16'h9988);
    chk("t6_dv", word_dv, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
